// File: rtl/bcd_to_unsigned.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, subtract-3 correction).
// Trigger/idle handshake; flags any input nibble above 9 and forces bin to zero in that case.
module bcd_to_unsigned #(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trigger,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  idle,
    output logic [BIN_W-1:0]      bin,
    output logic                  valid,
    output logic                  error
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BCD_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BCD_W-1:0]    r_digits;
    logic [BCD_W-1:0]    r_acc;
    logic                r_err_pending;
    logic [CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]    r_bin;
    logic                r_error;
    logic                r_valid;

    logic                w_bad_digit;
    logic [BCD_W-1:0]    w_digits_shifted;
    logic [BCD_W-1:0]    w_digits_corr;
    logic [BCD_W-1:0]    w_acc_shifted;
    logic                w_last_iter;

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) w_bad_digit = 1'b1;
        end
    end

    // Each nibble is corrected on its own; operands are >= 8 so no borrow crosses nibbles.
    always_comb begin
        w_digits_shifted = r_digits >> 1;
        w_acc_shifted    = {r_digits[0], r_acc[BCD_W-1:1]};
        w_digits_corr    = w_digits_shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_digits_shifted[4*i+3]) begin
                w_digits_corr[4*i +: 4] = w_digits_shifted[4*i +: 4] - 4'd3;
            end
        end
    end

    assign w_last_iter = (r_cnt == CNT_W'(BCD_W - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (trigger) w_state_next = SHIFT;
            SHIFT:   if (w_last_iter) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the working registers are reset too; an aborted conversion must leave nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits      <= '0;
            r_acc         <= '0;
            r_err_pending <= 1'b0;
            r_cnt         <= '0;
            r_bin         <= '0;
            r_error       <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (trigger) begin
                        r_digits      <= bcd;
                        r_acc         <= '0;
                        r_err_pending <= w_bad_digit;
                        r_cnt         <= '0;
                    end
                end
                SHIFT: begin
                    r_digits <= w_digits_corr;
                    r_acc    <= w_acc_shifted;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    r_bin   <= r_err_pending ? '0 : r_acc[BIN_W-1:0];
                    r_error <= r_err_pending;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign idle  = (r_state == IDLE);
    assign bin   = r_bin;
    assign error = r_error;
    assign valid = r_valid;

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Directed self-checking bench for bcd_to_unsigned: latency, results, error flag,
// back-to-back throughput, ignored triggers and asynchronous abort.
module tb_bcd_to_unsigned;
    logic        clk;
    logic        rst_n;
    logic        trigger;
    logic [31:0] bcd;
    logic        idle;
    logic [26:0] bin;
    logic        valid;
    logic        error;

    int total = 0;
    int bad   = 0;

    bcd_to_unsigned #(.DIGITS(8), .BIN_W(27)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (trigger),
        .bcd     (bcd),
        .idle    (idle),
        .bin     (bin),
        .valid   (valid),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!idle && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle_wait"}, 32'(idle), 32'd1);
    endtask

    // Accept one operand and check latency, idle-low duration and the result.
    task automatic run_conv(input string tag, input logic [31:0] operand,
                            input logic [31:0] exp_bin, input logic exp_err);
        int edges = 0;
        int low   = 0;
        wait_idle(tag);
        bcd     = operand;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        while (!valid && edges < 100) begin
            if (!idle) low++;
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd33);
        check({tag, "_idle_low"}, 32'(low), 32'd33);
        check({tag, "_bin"}, 32'(bin), exp_bin);
        check({tag, "_err"}, 32'(error), 32'(exp_err));
        check({tag, "_idle_at_valid"}, 32'(idle), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_valid_1cyc"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int edge_no;
        int v1;
        int v2;
        int pulses;
        int unstable;
        logic [31:0] bin_seen;

        rst_n   = 1'b0;
        trigger = 1'b0;
        bcd     = '0;
        #23;
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_bin", 32'(bin), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_conv("hhmmss", 32'h0023_5959, 32'h0399B7, 1'b0);
        run_conv("max", 32'h9999_9999, 32'h5F5E0FF, 1'b0);
        run_conv("zero", 32'h0000_0000, 32'd0, 1'b0);
        run_conv("badnib", 32'h0012_A456, 32'd0, 1'b1);
        run_conv("after_bad", 32'h0000_0001, 32'd1, 1'b0);

        // Trigger held high: two back-to-back conversions; bcd changes after the first acceptance.
        wait_idle("thru");
        bcd     = 32'h0000_0059;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        bcd      = 32'h0000_0100;
        edge_no  = 0;
        v1       = -1;
        v2       = -1;
        unstable = 0;
        bin_seen = '0;
        while (v2 < 0 && edge_no < 200) begin
            @(posedge clk);
            #1;
            edge_no++;
            if (valid) begin
                if (v1 < 0) begin
                    v1       = edge_no;
                    bin_seen = 32'(bin);
                    check("thru_bin1", 32'(bin), 32'd59);
                end else begin
                    v2 = edge_no;
                    check("thru_bin2", 32'(bin), 32'd100);
                end
            end else if (v1 >= 0) begin
                trigger = 1'b0;
                if (32'(bin) != bin_seen) unstable++;
            end
        end
        trigger = 1'b0;
        check("thru_first_lat", 32'(v1), 32'd33);
        check("thru_period", 32'(v2 - v1), 32'd34);
        check("thru_bin_stable", 32'(unstable), 32'd0);

        // A trigger during SHIFT with another operand must be ignored.
        wait_idle("ign");
        bcd     = 32'h0000_4321;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bcd     = 32'h0000_9876;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 80; i++) begin
            if (valid) begin
                pulses++;
                check("ign_bin", 32'(bin), 32'd4321);
            end
            @(posedge clk);
            #1;
        end
        check("ign_pulses", 32'(pulses), 32'd1);

        // Asynchronous abort 10 cycles into a conversion.
        wait_idle("abort");
        bcd     = 32'h0000_5555;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_idle", 32'(idle), 32'd1);
        check("abort_bin", 32'(bin), 32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_err", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        check("abort_no_valid", 32'(pulses), 32'd0);
        run_conv("post_abort", 32'h0000_1234, 32'd1234, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
